// File: rtl/i2c_passcode_sequencer.sv
// i2c_passcode_sequencer: issues the passcode bytes as single-byte I2C writes with retry on NACK and an idle gap between commands
module i2c_passcode_sequencer #(
  parameter logic [6:0] DEV_ADDR   = 7'h0A,
  parameter logic [7:0] BASE_REG   = 8'h05,
  parameter int         NUM_BYTES  = 6,
  parameter int         GAP_CYCLES = 10,
  parameter int         MAX_RETRY  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pc_we,
  input  logic [2:0] pc_idx,
  input  logic [7:0] pc_wdata,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [6:0] cmd_dev_addr,
  output logic [7:0] cmd_reg_addr,
  output logic [7:0] cmd_data,
  input  logic       rsp_valid,
  input  logic       rsp_nack,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] byte_idx
);
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [63:0] DEF = 64'h0000_584E_4753_4850;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, GAP} state_t;
  state_t state, state_n;
  logic [7:0] tbl [8];
  logic [2:0] retry;
  logic [GW-1:0] gap_cnt;
  logic accept, ack, nack, last, abort;
  assign accept       = state == IDLE && start;
  assign ack          = state == WAIT_RSP && rsp_valid && !rsp_nack;
  assign nack         = state == WAIT_RSP && rsp_valid && rsp_nack;
  assign last         = byte_idx == 3'(NUM_BYTES - 1);
  assign abort        = nack && retry == 3'(MAX_RETRY);
  assign cmd_valid    = state == ISSUE;
  assign busy         = state != IDLE;
  assign cmd_dev_addr = DEV_ADDR;
  assign cmd_reg_addr = BASE_REG + {5'd0, byte_idx};
  assign cmd_data     = tbl[byte_idx];
  always_comb begin
    state_n = state;
    state_n = accept                             ? ISSUE
            : (state == ISSUE && cmd_ready)      ? WAIT_RSP
            : ((ack && last) || abort)           ? IDLE
            : (ack || nack)                      ? GAP
            : (state == GAP && gap_cnt == '0)    ? ISSUE
            : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_idx <= '0;
      retry    <= '0;
      gap_cnt  <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      for (int i = 0; i < 8; i++) tbl[i] <= DEF[i*8 +: 8];
    end else begin
      state <= state_n;
      done  <= ack && last;
      if (state == IDLE && pc_we) tbl[pc_idx] <= pc_wdata;
      if (accept) begin
        byte_idx <= '0;
        retry    <= '0;
        error    <= 1'b0;
      end
      if (ack && !last) begin
        byte_idx <= byte_idx + 1'b1;
        retry    <= '0;
      end
      if (nack) retry <= retry + 1'b1;
      if (abort) error <= 1'b1;
      gap_cnt <= (state_n == GAP && state != GAP) ? GW'(GAP_CYCLES - 1)
               : (state == GAP)                   ? gap_cnt - 1'b1
               : gap_cnt;
    end
  end
endmodule

// File: tb/tb_i2c_passcode_sequencer.sv
// tb_i2c_passcode_sequencer: directed checks of the passcode write sequencer
module tb_i2c_passcode_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pc_we = 1'b0;
  logic [2:0] pc_idx = '0;
  logic [7:0] pc_wdata = '0;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic [6:0] cmd_dev_addr;
  logic [7:0] cmd_reg_addr;
  logic [7:0] cmd_data;
  logic       rsp_valid = 1'b0;
  logic       rsp_nack = 1'b0;
  logic       busy, done, error;
  logic [2:0] byte_idx;
  int n_chk = 0;
  int n_fail = 0;
  int g;
  logic [7:0] exp_d [6];

  i2c_passcode_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .pc_we(pc_we), .pc_idx(pc_idx), .pc_wdata(pc_wdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dev_addr(cmd_dev_addr),
    .cmd_reg_addr(cmd_reg_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_nack(rsp_nack),
    .busy(busy), .done(done), .error(error), .byte_idx(byte_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic set_default();
    exp_d[0] = 8'h50; exp_d[1] = 8'h48; exp_d[2] = 8'h53;
    exp_d[3] = 8'h47; exp_d[4] = 8'h4E; exp_d[5] = 8'h58;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_cmd(input int idx, input bit nack, input int stall, input bit no_rsp, output int gap);
    gap = 0;
    while (!cmd_valid && gap < 100) begin
      @(negedge clk);
      gap++;
    end
    chk("cmd_valid_seen", cmd_valid, 1);
    chk("dev_addr", cmd_dev_addr, 7'h0A);
    chk("byte_idx", byte_idx, idx);
    chk("reg_addr", cmd_reg_addr, 8'h05 + idx);
    chk("data", cmd_data, exp_d[idx]);
    chk("busy_in_seq", busy, 1);
    cmd_ready = 1'b0;
    repeat (stall) begin
      @(negedge clk);
      chk("hold_valid", cmd_valid, 1);
      chk("hold_reg", cmd_reg_addr, 8'h05 + idx);
      chk("hold_data", cmd_data, exp_d[idx]);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk("valid_drop", cmd_valid, 0);
    if (!no_rsp) begin
      rsp_valid = 1'b1;
      rsp_nack  = nack;
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
    end
  endtask

  task automatic run_rest(input int from);
    int gg;
    for (int i = from; i < 6; i++) begin
      do_cmd(i, 1'b0, 0, 1'b0, gg);
      if (i > from) chk("gap_len", gg, 10);
      if (i < 5) chk("no_early_done", done, 0);
    end
    chk("done_pulse", done, 1);
    chk("busy_clear", busy, 0);
    chk("no_error", error, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    set_default();
    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_byte_idx", byte_idx, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: clean sequence, ready engine, all ACK
    pulse_start();
    chk("start_latency_valid", cmd_valid, 1);
    run_rest(0);

    // 2: cmd_ready stalled at byte 2
    pulse_start();
    do_cmd(0, 1'b0, 0, 1'b0, g);
    chk("start_latency", g, 0);
    do_cmd(1, 1'b0, 0, 1'b0, g);
    do_cmd(2, 1'b0, 5, 1'b0, g);
    chk("gap_before_stall", g, 10);
    run_rest(3);

    // 3: byte 3 NACKed twice, then ACK
    pulse_start();
    for (int i = 0; i < 3; i++) do_cmd(i, 1'b0, 0, 1'b0, g);
    do_cmd(3, 1'b1, 0, 1'b0, g);
    chk("nack1_no_error", error, 0);
    do_cmd(3, 1'b1, 0, 1'b0, g);
    chk("retry_gap", g, 10);
    do_cmd(3, 1'b0, 0, 1'b0, g);
    chk("retry2_gap", g, 10);
    run_rest(4);

    // 4: byte 0 NACKed past retry limit
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      do_cmd(0, 1'b1, 0, 1'b0, g);
      if (i < 3) chk("abort_not_yet", busy, 1);
    end
    chk("abort_error", error, 1);
    chk("abort_busy", busy, 0);
    chk("abort_no_done", done, 0);
    @(negedge clk);
    chk("abort_idle_valid", cmd_valid, 0);
    chk("abort_error_sticky", error, 1);
    chk("abort_no_done2", done, 0);
    pulse_start();
    chk("restart_clears_error", error, 0);
    chk("restart_busy", busy, 1);
    run_rest(0);

    // 5: table writes in IDLE apply, writes and start while busy are ignored
    pc_we = 1'b1; pc_idx = 3'd0; pc_wdata = 8'hA5;
    @(negedge clk);
    pc_idx = 3'd2; pc_wdata = 8'hC3; start = 1'b1;
    @(negedge clk);
    pc_we = 1'b0; start = 1'b0;
    exp_d[0] = 8'hA5; exp_d[2] = 8'hC3;
    do_cmd(0, 1'b0, 0, 1'b0, g);
    pc_we = 1'b1; pc_idx = 3'd1; pc_wdata = 8'hFF; start = 1'b1;
    @(negedge clk);
    pc_we = 1'b0; start = 1'b0;
    run_rest(1);

    // 6: reset while waiting for the byte 4 response
    pulse_start();
    for (int i = 0; i < 4; i++) do_cmd(i, 1'b0, 0, 1'b0, g);
    do_cmd(4, 1'b0, 0, 1'b1, g);
    chk("wait_rsp_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_cmd_valid", cmd_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_error", error, 0);
    chk("midrst_byte_idx", byte_idx, 0);
    set_default();
    repeat (2) @(negedge clk);
    chk("midrst_stays_idle", busy, 0);
    pulse_start();
    run_rest(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
